// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx
//   Transmit end of the edge-detection pipeline. Pixels from the filter core
//   are buffered in a small FIFO, then streamed downstream through a single
//   output register carrying raster framing flags (SOF / EOL / EOF).
//
//   Optional build macro: PIXEL_TX_THRESH_EN
//     defined   -> each pixel is binarised at load time (>= THRESHOLD -> 8'hFF,
//                  else 8'h00)
//     undefined -> pixels pass through unmodified; THRESHOLD is unused
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   tx_en                  transmit enable, acted on only at frame boundaries
//   in_pixel/in_valid      write side from the filter core
//   in_ready               FIFO not full
//   out_pixel/out_valid    output beat, held stable while !out_ready
//   out_ready              downstream accept
//   out_sof/out_eol/out_eof raster flags travelling with the beat
//   frame_done             one-cycle pulse after the EOF beat is accepted
//   overflow               sticky: a pixel was offered while the FIFO was full
module pixel_stream_tx #(
    parameter int         IMG_WIDTH  = 64,
    parameter int         IMG_HEIGHT = 64,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] THRESHOLD  = 8'd128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] in_pixel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof,
    output logic       frame_done,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // One output beat: pixel plus the flags computed when it was loaded.
    typedef struct packed {
        logic [7:0] pixel;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit so full/empty are unambiguous
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        wr_en;
    logic        rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A read in the same cycle does not free a slot for a write while full.
    assign in_ready = !full;
    assign wr_en    = in_valid && !full;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= in_pixel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pixel transform applied on the way into the output register
    // ------------------------------------------------------------------
    logic [7:0] head;
    logic [7:0] load_pixel;

    assign head = mem[rd_ptr[AW-1:0]];

`ifdef PIXEL_TX_THRESH_EN
    assign load_pixel = (head >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    assign load_pixel = head;
    logic unused_thresh;
    assign unused_thresh = ^THRESHOLD;
`endif

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          eof_accept;
    logic          stop_at_eof;
    logic          load;
    beat_t         beat_q;
    beat_t         beat_nxt;

    assign accept      = out_valid && out_ready;
    assign eof_accept  = accept && out_eof;
    // When the frame ends with tx_en low, the next frame's first pixel must
    // stay in the FIFO, so the load that would normally overlap the EOF
    // acceptance is suppressed.
    assign stop_at_eof = eof_accept && !tx_en;
    assign load        = (state == S_STREAM) && !empty &&
                         (!out_valid || out_ready) && !stop_at_eof;
    assign rd_en       = load;

    always_comb begin
        beat_nxt.pixel = load_pixel;
        beat_nxt.sof   = (col == '0) && (row == '0);
        beat_nxt.eol   = (col == COL_LAST);
        beat_nxt.eof   = (col == COL_LAST) && (row == ROW_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (tx_en)       state_nxt = S_STREAM;
            S_STREAM: if (stop_at_eof) state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // col/row name the pixel that the next load will place in the output
    // register; they advance only on loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output register: load has priority; otherwise an accepted beat just
    // drops valid and leaves the data as it was.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q    <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            beat_q    <= beat_nxt;
            out_valid <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pixel = beat_q.pixel;
    assign out_sof   = beat_q.sof;
    assign out_eol   = beat_q.eol;
    assign out_eof   = beat_q.eof;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= eof_accept;
            if (in_valid && full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_stream_tx.sv
module tb_pixel_stream_tx;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    logic       frame_done;
    logic       overflow;

    pixel_stream_tx #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .FIFO_DEPTH(D),
        .THRESHOLD (8'd128)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_en     (tx_en),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted pixel is queued in order; the n-th
    // beat of the stream sits at raster position (n mod W, (n div W) mod H).
    logic [7:0] sb[$];
    int         beats = 0;
    bit         exp_fd = 1'b0;
    int         first_valid_cyc = -1;

    function automatic logic [7:0] model_pix(input logic [7:0] p);
`ifdef PIXEL_TX_THRESH_EN
        return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    // Monitor: checks the presented beat against the head of the queue
    // every cycle it is valid (which also covers holding under backpressure).
    always @(negedge clk) begin : mon
        int col;
        int row;
        if (!reset) begin
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            exp_fd = 1'b0;
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    check("beat_without_pixel", 32'(out_valid), 32'd0);
                end else begin
                    col = beats % W;
                    row = (beats / W) % H;
                    check("beat", 32'({out_pixel, out_sof, out_eol, out_eof}),
                          32'({sb[0], (col == 0 && row == 0), (col == W-1),
                               (col == W-1 && row == H-1)}));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        beats++;
                        if (col == W-1 && row == H-1) exp_fd = 1'b1;
                    end
                end
            end
            if (in_valid) begin
                // Fewer than D pixels in flight means the FIFO cannot be full.
                if (sb.size() < D) check("in_ready_free", 32'(in_ready), 32'd1);
                if (in_ready) sb.push_back(model_pix(in_pixel));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete();
        beats = 0;
        exp_fd = 1'b0;
        first_valid_cyc = -1;
        #1 reset = 1'b0;
    endtask

    task automatic wr(input logic [7:0] p);
        in_valid = 1'b1;
        in_pixel = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, sb.size(), 32'd0);
    endtask

    task automatic wait_beats(input int k, input int budget);
        int n = 0;
        while (beats < k && n < budget) begin
            tick();
            n++;
        end
        check("beats_reached", 32'(beats >= k), 32'd1);
    endtask

    int wr_cyc;

    initial begin
        // Reset, then idle with tx_en low
        tx_en = 1'b0; out_ready = 1'b0;
        do_reset();
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_pixel",  32'(out_pixel),  32'd0);
        check("rst_flags",      32'({out_sof, out_eol, out_eof}), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        wr(8'd1); wr(8'd2); wr(8'd3);
        out_ready = 1'b1;
        repeat (5) tick();
        check("idle_no_valid", 32'(out_valid), 32'd0);

        // 4x2 frame back-to-back, latency, then threshold patterns
        tx_en = 1'b1; out_ready = 1'b1;
        do_reset();
        tick(); tick();
        wr_cyc = cyc;
        for (int p = 1; p <= 8; p++) wr(8'(p));
        drain("drain_frame", 50);
        check("latency", 32'(first_valid_cyc - wr_cyc), 32'd2);
        wr(8'd127); wr(8'd128); wr(8'd200); wr(8'd0);
        drain("drain_thresh", 50);

        // Backpressure hold
        out_ready = 1'b0;
        do_reset();
        tick(); tick();
        wr(8'h3C); wr(8'h11); wr(8'h22);
        repeat (5) tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_pixel", 32'(out_pixel), 32'(model_pix(8'h3C)));
        out_ready = 1'b1;
        drain("drain_bp", 50);

        // Overflow with the block idle so nothing leaves the FIFO
        tx_en = 1'b0; out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < D; i++) wr(8'(8'h40 + i));
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("ovf_before",    32'(overflow), 32'd0);
        wr(8'h99);
        check("ovf_set",       32'(overflow), 32'd1);
        check("ovf_kept",      sb.size(), 32'(D));
        repeat (3) tick();
        tx_en = 1'b1; out_ready = 1'b1;
        drain("drain_ovf", 100);
        check("ovf_sticky",    32'(overflow), 32'd1);

        // tx_en dropped mid-frame: frame completes, next frame waits
        tx_en = 1'b1; out_ready = 1'b0;
        do_reset();
        tick(); tick();
        for (int p = 1; p <= 8; p++) wr(8'(8'h50 + p));
        out_ready = 1'b1;
        wait_beats(3, 50);
        tx_en = 1'b0;
        for (int p = 0; p < 4; p++) wr(8'(8'hA0 + p));
        wait_beats(8, 50);
        repeat (10) tick();
        check("stop_no_valid",  32'(out_valid), 32'd0);
        check("stop_buffered",  sb.size(), 32'd4);
        tx_en = 1'b1;
        drain("drain_resume", 50);

        // Randomised traffic with backpressure
        tx_en = 1'b1; out_ready = 1'b1;
        do_reset();
        tick(); tick();
        for (int i = 0; i < 1500; i++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_pixel  = 8'($urandom);
            out_ready = $urandom_range(0, 9) < 7;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("drain_random", 100);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
